// File: rtl/mips_pkg.sv
// Purpose: shared widths, fetch FSM state encoding and PC helpers for the fetch stage.
// Latency: n/a (types, constants and one pure function only).
// Backpressure: n/a.
package mips_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    // Sequential fetch advances by one 32-bit instruction word.
    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    // ISSUE: may launch a read; WAIT: one read in flight;
    // DRAIN: read in flight whose response must be thrown away.
    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Instruction addresses are word aligned; low two bits are never meaningful.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Purpose: fetch program counter; reset to RESET_PC, +4 on slot load, redirect load.
// Latency: new PC visible the cycle after inc_i/load_i.
// Backpressure: none; holds value when neither inc_i nor load_i is asserted.
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc_i,
    input  logic            load_i,
    input  logic [XLEN-1:0] load_pc_i,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    // Redirect has priority over the sequential increment; the add wraps at 2^32.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = word_align(load_pc_i);
        end else if (inc_i) begin
            pc_d = pc_q + PC_INC;
        end
    end

    // PC register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= word_align(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Purpose: instruction fetch stage, one outstanding imem read, single output slot; optional perf counters under FETCH_PERF_CNT_EN.
// Latency: imem_req in cycle N, imem_valid in N+k (k>=1), if_valid from N+k+1.
// Backpressure: stall_i holds the output slot and blocks new requests while the slot is occupied.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [XLEN-1:0]    if_pc,
    output logic [XLEN-1:0]    if_pc_plus4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_squashed
`endif
);

    fetch_state_t        state_q;
    logic                if_valid_q;
    logic [INSTR_W-1:0]  if_instr_q;
    logic [XLEN-1:0]     if_pc_q;
    logic [XLEN-1:0]     pc;

    logic slot_free;
    logic issue;
    logic load;
    logic squash;

    // The slot can take a new word if it is empty or is being consumed right now.
    assign slot_free = !if_valid_q || !stall_i;

    // A request only goes out from ISSUE; redirect and reset both suppress it.
    assign issue  = !rst && (state_q == ISSUE) && slot_free && !redirect_i;

    // Response is kept only in WAIT with no redirect arriving in the same cycle.
    assign load   = (state_q == WAIT) && imem_valid && !redirect_i;

    // Responses that arrive after (or together with) a redirect are dropped.
    assign squash = ((state_q == WAIT) && imem_valid && redirect_i) ||
                    ((state_q == DRAIN) && imem_valid);

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .inc_i     (load),
        .load_i    (redirect_i),
        .load_pc_i (redirect_pc),
        .pc_o      (pc)
    );

    // Fetch FSM and output slot; redirect flushes the slot even under stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ISSUE;
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
            if_pc_q    <= '0;
        end else begin
            unique case (state_q)
                ISSUE: begin
                    if (issue) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_valid) begin
                        state_q <= ISSUE;
                    end else if (redirect_i) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (imem_valid) begin
                        state_q <= ISSUE;
                    end
                end
                default: begin
                    state_q <= ISSUE;
                end
            endcase

            if (redirect_i) begin
                if_valid_q <= 1'b0;
            end else if (load) begin
                if_valid_q <= 1'b1;
                if_instr_q <= imem_rdata;
                if_pc_q    <= pc;
            end else if (if_valid_q && !stall_i) begin
                if_valid_q <= 1'b0;
            end
        end
    end

    assign imem_req    = issue;
    assign imem_addr   = pc;
    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc_q + PC_INC;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_squashed_q;

    // Free-running event counters: slot loads and discarded responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q  <= '0;
            perf_squashed_q <= '0;
        end else begin
            if (load) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (squash) begin
                perf_squashed_q <= perf_squashed_q + 32'd1;
            end
        end
    end

    assign perf_fetched  = perf_fetched_q;
    assign perf_squashed = perf_squashed_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: hand-written corner sequences plus a table of
// redirect-and-stream vectors checked through an expected-PC scoreboard.
// A second instance with RESET_PC = 0xFFFF_FFFC checks start-up wrap.
`timescale 1ns/1ps
module tb_instr_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        imem_req, imem_valid, stall_i, redirect_i, if_valid;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, if_instr, if_pc, if_pc_plus4;

    logic        b_req, b_valid, b_if_valid;
    logic [31:0] b_addr, b_rdata, b_instr, b_pc, b_pc4;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_squashed, b_perf_f, b_perf_s;
`endif

    int          nchecks = 0;
    int          nerr    = 0;
    int          mem_lat = 1;
    bit          mon_en  = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] b_seen[2];
    int          b_n = 0;

    typedef struct {
        int          lat;
        logic [31:0] redir_raw;
        logic [31:0] exp_first_pc;
        int          n;
    } vec_t;
    vec_t tbl[4];

    instr_fetch u_dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .stall_i     (stall_i),
        .redirect_i  (redirect_i),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_plus4 (if_pc_plus4)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_squashed (perf_squashed)
`endif
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (b_req),
        .imem_addr   (b_addr),
        .imem_valid  (b_valid),
        .imem_rdata  (b_rdata),
        .stall_i     (1'b0),
        .redirect_i  (1'b0),
        .redirect_pc (32'h0),
        .if_valid    (b_if_valid),
        .if_instr    (b_instr),
        .if_pc       (b_pc),
        .if_pc_plus4 (b_pc4)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched  (b_perf_f),
        .perf_squashed (b_perf_s)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_FFFF;
        return {~a[15:0], a[15:0]} ^ 32'h5A00_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory model for the main instance: samples requests mid-cycle, answers after mem_lat cycles.
    initial begin : mem_a
        bit          pend;
        int          cnt;
        logic [31:0] paddr;
        pend = 1'b0; cnt = 0; paddr = '0;
        imem_valid = 1'b0;
        imem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
            end else if (imem_req && !pend) begin
                pend  = 1'b1;
                paddr = imem_addr;
                cnt   = mem_lat;
            end
            @(posedge clk);
            #1;
            imem_valid = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt <= 0) begin
                    imem_valid = 1'b1;
                    imem_rdata = mem_word(paddr);
                    pend       = 1'b0;
                end
            end
        end
    end

    // One-cycle memory for the wrap instance; records its first two request addresses.
    initial begin : mem_b
        bit          pend;
        logic [31:0] paddr;
        pend = 1'b0; paddr = '0;
        b_valid = 1'b0;
        b_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
            end else if (b_req && !pend) begin
                pend  = 1'b1;
                paddr = b_addr;
                if (b_n < 2) b_seen[b_n] = b_addr;
                b_n++;
            end
            @(posedge clk);
            #1;
            b_valid = 1'b0;
            if (pend) begin
                b_valid = 1'b1;
                b_rdata = mem_word(paddr);
                pend    = 1'b0;
            end
        end
    end

    // Scoreboard: every consumed slot must match the next expected PC.
    initial begin : mon
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (imem_req) chk("addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
            if (mon_en && !rst && !redirect_i && if_valid && !stall_i) begin
                if (exp_q.size() == 0) begin
                    nchecks++;
                    nerr++;
                    $display("FAIL sb_spurious: consumed pc %h with nothing expected", if_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", if_pc, e);
                    chk("sb_instr", if_instr, mem_word(e));
                    chk("sb_pc_plus4", if_pc_plus4, e + 32'd4);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        tbl[0] = '{1, 32'h0000_1002, 32'h0000_1000, 6};
        tbl[1] = '{2, 32'h0000_2000, 32'h0000_2000, 5};
        tbl[2] = '{4, 32'hFFFF_FFF9, 32'hFFFF_FFF8, 4};
        tbl[3] = '{1, 32'h8000_0003, 32'h8000_0000, 8};

        rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_pc_plus4", if_pc_plus4, 32'h4);
        chk("rst_imem_req", {31'b0, imem_req}, 32'h0);

        // First fetch with a 1-cycle memory, stall asserted ahead of the load.
        step(); rst = 1'b0; stall_i = 1'b1;
        @(negedge clk);
        chk("first_req", {31'b0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, 32'h0);
        step(); @(negedge clk);
        chk("not_early", {31'b0, if_valid}, 32'h0);
        step(); @(negedge clk);
        chk("first_valid", {31'b0, if_valid}, 32'h1);
        chk("first_instr", if_instr, 32'h2008_FFFF);
        chk("first_pc", if_pc, 32'h0);
        chk("first_pc_plus4", if_pc_plus4, 32'h4);
        chk("stall_no_req0", {31'b0, imem_req}, 32'h0);
        for (int i = 0; i < 2; i++) begin
            step(); @(negedge clk);
            chk("stall_hold_instr", if_instr, 32'h2008_FFFF);
            chk("stall_hold_valid", {31'b0, if_valid}, 32'h1);
            chk("stall_no_req", {31'b0, imem_req}, 32'h0);
        end
        mem_lat = 3;
        step(); stall_i = 1'b0;
        @(negedge clk);
        chk("unstall_req", {31'b0, imem_req}, 32'h1);
        chk("unstall_addr", imem_addr, 32'h4);

        // Redirect while waiting; the late response must be drained.
        step(); redirect_i = 1'b1; redirect_pc = 32'h0000_0103;
        @(negedge clk);
        chk("redir_wait_no_req", {31'b0, imem_req}, 32'h0);
        step(); redirect_i = 1'b0;
        @(negedge clk);
        chk("drain_no_req", {31'b0, imem_req}, 32'h0);
        chk("drain_if_valid", {31'b0, if_valid}, 32'h0);
        step(); @(negedge clk);
        chk("drain_resp_no_req", {31'b0, imem_req}, 32'h0);
        step(); @(negedge clk);
        chk("after_drain_req", {31'b0, imem_req}, 32'h1);
        chk("after_drain_addr", imem_addr, 32'h0000_0100);
        chk("after_drain_valid", {31'b0, if_valid}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_squashed_1", perf_squashed, 32'd1);
        chk("perf_fetched_1", perf_fetched, 32'd1);
`endif

        // Redirect in the same cycle as the response, under stall.
        step(); @(negedge clk);
        chk("wait_no_req", {31'b0, imem_req}, 32'h0);
        step();
        step(); redirect_i = 1'b1; redirect_pc = 32'h0000_0200; stall_i = 1'b1;
        @(negedge clk);
        chk("redir_valid_no_req", {31'b0, imem_req}, 32'h0);
        step(); redirect_i = 1'b0; stall_i = 1'b0;
        @(negedge clk);
        chk("redir_valid_if_valid", {31'b0, if_valid}, 32'h0);
        chk("redir_valid_req", {31'b0, imem_req}, 32'h1);
        chk("redir_valid_addr", imem_addr, 32'h0000_0200);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_squashed_2", perf_squashed, 32'd2);
`endif

        // Reset while a request is outstanding.
        step(); rst = 1'b1;
        @(negedge clk);
        chk("rst_wait_no_req", {31'b0, imem_req}, 32'h0);
        step(); rst = 1'b0;
        @(negedge clk);
        chk("rst2_if_valid", {31'b0, if_valid}, 32'h0);
        chk("rst2_if_instr", if_instr, 32'h0);
        chk("rst2_if_pc", if_pc, 32'h0);
        chk("rst2_if_pc_plus4", if_pc_plus4, 32'h4);
        chk("rst2_req", {31'b0, imem_req}, 32'h1);
        chk("rst2_addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst2_perf_fetched", perf_fetched, 32'd0);
        chk("rst2_perf_squashed", perf_squashed, 32'd0);
`endif

        // Table: redirect to a start PC, then stream with random stalls.
        for (int r = 0; r < 4; r++) begin
            int guard;
            step();
            mem_lat     = tbl[r].lat;
            redirect_i  = 1'b1;
            redirect_pc = tbl[r].redir_raw;
            stall_i     = 1'b1;
            for (int i = 0; i < tbl[r].n; i++) exp_q.push_back(tbl[r].exp_first_pc + 32'(4 * i));
            mon_en = 1'b1;
            step();
            redirect_i = 1'b0;
            guard = 0;
            while (exp_q.size() != 0 && guard < 400) begin
                stall_i = ($urandom_range(0, 3) == 0);
                step();
                guard++;
            end
            if (exp_q.size() != 0) begin
                nchecks++;
                nerr++;
                $display("FAIL stream_timeout: row %0d left %0d expected, required 0", r, exp_q.size());
                exp_q.delete();
            end
            stall_i = 1'b1;
        end

        chk("wrap_first_addr", b_seen[0], 32'hFFFF_FFFC);
        chk("wrap_second_addr", b_seen[1], 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
